csla_stream_accumulator_16: RTL and testbench
=============================================

Name: csla_stream_accumulator_16

Overview:
- Sequential stage directly downstream of the team's 16-bit carry-select adder.
- Consumes a valid/ready stream of 16-bit operands and accumulates them, one term per cycle, through the adder.
- Captures the adder's sum and carry-out into an accumulator register.
- Presents the finished total, a sticky overflow flag and a term count on a valid/ready output port.

Parameters:
WIDTH, 16, operand/accumulator width; the adder instance is fixed at 16, so only 16 is supported.
MAX_TERMS, 16, forced end of burst after this many accepted terms (range 1..255).
CNT_W, 5, count width; must equal $clog2(MAX_TERMS+1).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  operand
in_last  input  1  final operand of burst
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  accumulated total
out_carry  output  1  sticky: any adder carry-out during burst
out_count  output  CNT_W  number of terms accepted in burst

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n is low: state IDLE, accumulator 0, out_sum 0, out_carry 0, out_count 0, out_valid 0, in_ready 0.
- in_ready is combinational from state: 1 in IDLE and ACCUM, 0 in DONE, 0 while in reset.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- Datapath: adder a = accumulator, b = in_data, cin = 0. On accept:
  - acc <= sum
  - ovf <= ovf | cout
  - cnt <= cnt + 1
- FSM IDLE:
  - accumulator, ovf and cnt are 0.
  - An accepted beat goes to ACCUM, or to DONE if in_last=1 or MAX_TERMS==1.
- FSM ACCUM:
  - Each accepted beat updates acc, ovf and cnt.
  - Go to DONE when the accepted beat has in_last=1 or cnt+1 == MAX_TERMS.
  - Cycles with no beat hold all state.
- FSM DONE:
  - out_valid=1; out_sum, out_carry and out_count are driven from registers and stay stable until the handshake.
  - On out_ready=1, go to IDLE and clear acc, ovf and cnt in the same edge.
- Latency: out_valid rises in the cycle after the final beat is accepted.
- Throughput: 1 term/cycle within a burst, plus 1 bubble per result (in_ready=0 during DONE, including the handshake cycle).
- in_last arriving on the MAX_TERMS-th beat: single DONE entry, no double count.
- in_valid while in DONE: ignored; the upstream source holds its beat.
- Overflow: the sum wraps modulo 2^16, and out_carry records that a wrap occurred.
- out_count never exceeds MAX_TERMS and never wraps.
- Reset asserted mid-burst or in DONE: the partial result is discarded immediately, out_valid drops asynchronously, and no result is emitted for that burst.
- Outputs in IDLE/ACCUM: out_valid=0; out_sum/out_carry/out_count show the running register values and are don't-care to consumers.

Optional Feature:
CSLA_ACC_SATURATE_EN
- Defined: when the adder cout=1, acc <= 16'hFFFF instead of the wrapped sum. Once saturated, acc stays 16'hFFFF for the rest of the burst. out_carry is still set.
- Undefined: modulo-2^16 wrap as above.

Decomposition:
- Shared package/include csla_pkg holds: WIDTH=16, FSM state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2), and SAT_VALUE=16'hFFFF.
- One sub-module is natural: csla_acc_datapath_16. It contains the 16-bit carry-select adder instance, accumulator register, sticky-carry flop and saturation mux.
- The top holds the FSM, counter and handshakes.

Test Plan:
1. Beats 0x0001, 0x0002, 0x0003 (last on 3rd), out_ready=1 -> one cycle after 3rd accept: out_valid=1, out_sum=0x0006, out_carry=0, out_count=3; IDLE on the next edge.
2. Beats 0xFFFF, 0x0002 (last) -> out_sum=0x0001, out_carry=1, out_count=2; with CSLA_ACC_SATURATE_EN -> out_sum=0xFFFF, out_carry=1.
3. 16 back-to-back beats of 0x1000, in_last never set -> DONE after the 16th beat, out_sum=0x0000, out_carry=1, out_count=16; in_ready=0 on the following cycle.
4. out_ready held low for 5 cycles in DONE while in_valid=1 with data 0x00AA -> out_valid and out_sum stable; in_ready=0; 0x00AA not accepted until the cycle after the handshake; the next burst starts from 0.
5. rst_n pulsed low asynchronously after 2 of 4 beats (0x0010 each) -> outputs zero immediately; after release, burst 0x0005 (last) -> out_sum=0x0005, out_count=1.
6. Single beat 0x1234 with in_last=1 -> out_sum=0x1234, out_count=1; completing the handshake in the cycle out_valid rises yields back-to-back bursts separated by exactly one bubble.

Source files
------------

// File: rtl/csla_pkg.sv
// Shared constants for the carry-select stream accumulator: operand width,
// FSM state encodings and the saturation value.
package csla_pkg;
  localparam int WIDTH = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] SAT_VALUE = 16'hFFFF;
endpackage

// File: rtl/csla_acc_datapath_16.sv
// Accumulator datapath: 16-bit carry-select adder, accumulator register and sticky carry.
// Optional build macro CSLA_ACC_SATURATE_EN clamps the accumulator to SAT_VALUE on carry-out.
module csla_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [4:0] carry_s;

  assign carry_s[0] = cin;

  // Each 4-bit block precomputes both carry-in cases; the incoming carry only selects.
  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [4:0] r0_s;
    logic [4:0] r1_s;
    assign r0_s             = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign r1_s             = r0_s + 5'd1;
    assign sum[4*g +: 4]    = carry_s[g] ? r1_s[3:0] : r0_s[3:0];
    assign carry_s[g+1]     = carry_s[g] ? r1_s[4]   : r0_s[4];
  end

  assign cout = carry_s[4];
endmodule

module csla_acc_datapath_16
  import csla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);
  logic [WIDTH-1:0] acc_r;
  logic             ovf_r;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] acc_next_s;

  csla_adder_16 u_adder (
    .a    (acc_r),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Select wrapped or saturated sum for the accumulator update.
  always_comb begin
    acc_next_s = sum_s;
`ifdef CSLA_ACC_SATURATE_EN
    if (cout_s) begin
      acc_next_s = SAT_VALUE;
    end else begin
      acc_next_s = sum_s;
    end
`endif
  end

  // Accumulator and sticky carry registers; clear wins over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (clr) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (acc_en) begin
      acc_r <= acc_next_s;
      ovf_r <= ovf_r | cout_s;
    end else begin
      acc_r <= acc_r;
      ovf_r <= ovf_r;
    end
  end

  assign acc = acc_r;
  assign ovf = ovf_r;
endmodule

// File: rtl/csla_stream_accumulator_16.sv
// Stream accumulator top: burst FSM, term counter and valid/ready handshakes.
// Build macro CSLA_ACC_SATURATE_EN selects saturating accumulation in the datapath.
module csla_stream_accumulator_16
  import csla_pkg::ST_IDLE, csla_pkg::ST_ACCUM, csla_pkg::ST_DONE;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);
  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             accept_s;
  logic             handshake_s;
  logic             last_beat_s;
  logic             in_ready_s;
  logic [WIDTH-1:0] acc_s;
  logic             ovf_s;

  assign in_ready_s  = rst_n && ((state_r == ST_IDLE) || (state_r == ST_ACCUM));
  assign accept_s    = in_valid && in_ready_s;
  assign handshake_s = (state_r == ST_DONE) && out_ready;
  assign cnt_inc_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  // Reaching MAX_TERMS also covers MAX_TERMS==1 on the very first beat.
  assign last_beat_s = in_last || (cnt_inc_s == CNT_W'(MAX_TERMS));

  // Next-state decode for the burst FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_ACCUM: begin
        if (accept_s) begin
          state_next_s = last_beat_s ? ST_DONE : ST_ACCUM;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Term counter: cleared by the result handshake, bumped on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (handshake_s) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  csla_acc_datapath_16 u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_en  (accept_s),
    .clr     (handshake_s),
    .in_data (in_data),
    .acc     (acc_s),
    .ovf     (ovf_s)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == ST_DONE);
  assign out_sum   = acc_s;
  assign out_carry = ovf_s;
  assign out_count = cnt_r;
endmodule

// File: tb/tb_csla_stream_accumulator_16.sv
// Scoreboard bench for csla_stream_accumulator_16: directed bursts then random traffic.
module tb_csla_stream_accumulator_16;
  localparam int MAX_TERMS = 16;
  localparam int CNT_W     = 5;
`ifdef CSLA_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic [4:0]  count;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic             out_carry;
  logic [CNT_W-1:0] out_count;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_results = 0;
  int   n_expected = 0;

  logic [15:0] m_acc;
  logic        m_ovf;
  int          m_cnt;
  bit          m_done;

  bit   stalled = 1'b0;
  res_t held;
  res_t got;

  csla_stream_accumulator_16 #(.WIDTH(16), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_acc  = 16'h0000;
    m_ovf  = 1'b0;
    m_cnt  = 0;
    m_done = 1'b0;
  endtask

  // One clock of stimulus, called just after a rising edge; the model follows the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r);
    logic [16:0] t;
    res_t        e;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(!m_done));
    check("out_valid", 32'(out_valid), 32'(m_done));
    @(posedge clk);
    if (m_done) begin
      if (r) model_clear();
    end else if (v) begin
      t = {1'b0, m_acc} + {1'b0, d};
      if (t[16]) begin
        m_ovf = 1'b1;
        m_acc = SAT ? 16'hFFFF : t[15:0];
      end else begin
        m_acc = t[15:0];
      end
      m_cnt++;
      if (l || m_cnt == MAX_TERMS) begin
        m_done  = 1'b1;
        e.sum   = m_acc;
        e.carry = m_ovf;
        e.count = 5'(m_cnt);
        exp_q.push_back(e);
        n_expected++;
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    model_clear();
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each result handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      got = '{out_sum, out_carry, out_count};
      if (stalled) check("hold_stable", 32'(got), 32'(held));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got sum 0x%0h count %0d, required none", out_sum, out_count);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("out_sum", 32'(out_sum), 32'(e.sum));
          check("out_carry", 32'(out_carry), 32'(e.carry));
          check("out_count", 32'(out_count), 32'(e.count));
          n_results++;
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = got;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; out_ready = 1'b0;
    model_clear();
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sum", 32'(out_sum), 32'd0);
    check("reset_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simple three-term burst
    step(1'b1, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'h0002, 1'b0, 1'b1);
    step(1'b1, 16'h0003, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    // Wrap / saturation
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 16'h0002, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    // Forced end at MAX_TERMS, then more beats offered during DONE
    for (int i = 0; i < MAX_TERMS; i++) step(1'b1, 16'h1000, 1'b0, 1'b0);
    step(1'b1, 16'h1000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    // Last flag on the MAX_TERMS-th beat
    for (int i = 0; i < MAX_TERMS; i++) step(1'b1, 16'h0101, (i == MAX_TERMS - 1), 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    // Long stall with a pending beat
    step(1'b1, 16'h0007, 1'b1, 1'b0);
    repeat (5) step(1'b1, 16'h00AA, 1'b0, 1'b0);
    step(1'b1, 16'h00AA, 1'b1, 1'b1);
    step(1'b1, 16'h00AA, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    // Reset mid-burst
    step(1'b1, 16'h0010, 1'b0, 1'b1);
    step(1'b1, 16'h0010, 1'b0, 1'b1);
    pulse_reset();
    step(1'b1, 16'h0005, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    // Back-to-back single-beat bursts
    repeat (4) step(1'b1, 16'h1234, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    for (int i = 0; i < 500; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = d | 16'hF000;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (4) step(1'b0, 16'h0000, 1'b0, 1'b1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(n_results), 32'(n_expected));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
